// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave that maps bus transfers onto a single-port SRAM with no byte enables.
// Sub-word writes become read-modify-write; illegal transfers get a two-cycle ERROR response.
module ahb_sram_ctrl #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          hclk,
    input  logic          hrst_n,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [31:0]   haddr,
    input  logic [DW-1:0] hwdata,
    input  logic [1:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic          hready_in,
    output logic          hready_out,
    output logic [1:0]    hresp,
    output logic [DW-1:0] hrdata,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD, RD_OUT, WR, RMW_RD, RMW_WR, ERR1, ERR2
    } state_t;

    state_t        state_q, state_d;
    state_t        acceptState;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] lastAddr_q;
    logic [DW-1:0] lastWdata_q;
    logic          accept;
    logic          badXfer;
    logic [3:0]    laneMask;
    logic [DW-1:0] mergedData;
    logic          unusedBits;

    assign unusedBits = ^{hburst, hprot};

    assign hready_out = !(state_q == RD || state_q == RMW_RD || state_q == ERR1);
    assign accept     = hsel & htrans[1] & hready_in & hready_out;
    assign badXfer    = (|haddr[31:AW+2])
                      | (hsize == 2'd3)
                      | ((hsize == 2'd1) & haddr[0])
                      | ((hsize == 2'd2) & (|haddr[1:0]));

    always_comb begin
        if (badXfer)            acceptState = ERR1;
        else if (!hwrite)       acceptState = RD;
        else if (hsize == 2'd2) acceptState = WR;
        else                    acceptState = RMW_RD;
    end

    // Little-endian lane select for the pending sub-word write.
    always_comb begin
        if (size_q == 2'd0) laneMask = 4'b0001 << addr_q[1:0];
        else                laneMask = 4'b0011 << {addr_q[1], 1'b0};
        mergedData = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            mergedData[8*i +: 8] = laneMask[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        hresp     = 2'b00;
        hrdata    = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = lastAddr_q;
        mem_wdata = lastWdata_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = acceptState;
            end
            RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q[AW+1:2];
                state_d  = RD_OUT;
            end
            RD_OUT: begin
                hrdata  = mem_rdata;
                state_d = accept ? acceptState : IDLE;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q[AW+1:2];
                mem_wdata = hwdata;
                state_d   = accept ? acceptState : IDLE;
            end
            RMW_RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q[AW+1:2];
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q[AW+1:2];
                mem_wdata = mergedData;
                state_d   = accept ? acceptState : IDLE;
            end
            ERR1: begin
                hresp   = 2'b01;
                state_d = ERR2;
            end
            ERR2: begin
                hresp   = 2'b01;
                state_d = accept ? acceptState : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory address/data are remembered so they hold steady between strobes.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            lastAddr_q  <= '0;
            lastWdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lastAddr_q  <= mem_addr;
            lastWdata_q <= mem_wdata;
            if (accept) begin
                addr_q <= haddr[AW+1:0];
                size_q <= hsize;
            end
            if (state_q == RMW_RD) wdata_q <= hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl: table-driven AHB transfers with a response scoreboard,
// plus sequences for back-to-back pipelining, reset during read-modify-write and idle cycles.
module tb_ahb_sram_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          hclk = 1'b0;
    logic          hrst_n;
    logic          hsel;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [31:0]   haddr;
    logic [DW-1:0] hwdata;
    logic [1:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic          hready_in;
    logic          hready_out;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          mem_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic tieReady;
    logic forceReady;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [1:0]  expResp;
        logic [31:0] expData;
        int          expWaits;
        int          expRd;
        int          expWe;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          waits;
    } sb_t;

    sb_t           sbQ[$];
    vec_t          vecs[12];
    int            totalCnt = 0;
    int            badCnt   = 0;
    int            rdCnt    = 0;
    int            weCnt    = 0;
    int            cycleCnt = 0;
    logic [AW-1:0] lastStrobeAddr = '0;
    bit            pending  = 1'b0;
    int            waitCnt  = 0;
    logic [31:0]   sram [64];

    assign hready_in = tieReady ? hready_out : forceReady;

    always #5 hclk = ~hclk;

    ahb_sram_ctrl #(.DW(DW), .AW(AW)) dut (
        .hclk       (hclk),
        .hrst_n     (hrst_n),
        .hsel       (hsel),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hsize      (hsize),
        .hburst     (hburst),
        .hprot      (hprot),
        .hready_in  (hready_in),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // SRAM model: synchronous write, read data valid the cycle after the strobe.
    always @(posedge hclk) begin
        cycleCnt <= cycleCnt + 1;
        if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
            weCnt          <= weCnt + 1;
            lastStrobeAddr <= mem_addr;
        end
        if (mem_rd) begin
            mem_rdata      <= sram[mem_addr];
            rdCnt          <= rdCnt + 1;
            lastStrobeAddr <= mem_addr;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCnt++;
        if (actual !== expected) begin
            badCnt++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mkVec(bit w, logic [31:0] a, logic [1:0] s, logic [31:0] wd,
                                   logic [1:0] r, logic [31:0] d, int wt, int nr, int nw);
        vec_t v;
        v.write = w;  v.addr = a;    v.size = s;      v.wdata = wd;
        v.expResp = r; v.expData = d; v.expWaits = wt; v.expRd = nr; v.expWe = nw;
        return v;
    endfunction

    // Monitor: tracks data phases, pops the scoreboard when a data phase completes.
    initial begin : monitor
        sb_t exp;
        forever begin
            @(negedge hclk);
            if (!hrst_n) begin
                pending = 1'b0;
                waitCnt = 0;
            end else begin
                if (pending) begin
                    checkOutput("sb_has_entry", {31'd0, (sbQ.size() > 0)}, 32'd1);
                    if (sbQ.size() == 0) begin
                        pending = 1'b0;
                    end else begin
                        checkOutput("hresp_dataphase", {30'd0, hresp}, {30'd0, sbQ[0].resp});
                        if (!hready_out) begin
                            waitCnt++;
                        end else begin
                            exp = sbQ.pop_front();
                            checkOutput("hrdata", hrdata, exp.data);
                            checkOutput("wait_states", waitCnt, exp.waits);
                            pending = 1'b0;
                        end
                    end
                end
                if (hsel && htrans[1] && hready_in && hready_out) begin
                    pending = 1'b1;
                    waitCnt = 0;
                end
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hready_out && n < 20);
        if (!hready_out) checkOutput("ready_timeout", {31'd0, hready_out}, 32'd1);
        @(posedge hclk);
        #1;
    endtask

    // Drives one address phase, waits for it to be accepted, then supplies its write data.
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = v.write;
        haddr  = v.addr;
        hsize  = v.size;
        e.resp  = v.expResp;
        e.data  = (!v.write && v.expResp == 2'b00) ? v.expData : 32'd0;
        e.waits = v.expWaits;
        sbQ.push_back(e);
        waitReady();
        hwdata = v.wdata;
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic runRow(input vec_t v, input string tag);
        int rd0 = rdCnt;
        int we0 = weCnt;
        applyStimulus(v);
        waitReady();
        checkOutput({tag, "_rd_strobes"}, rdCnt - rd0, v.expRd);
        checkOutput({tag, "_we_strobes"}, weCnt - we0, v.expWe);
        if (v.expRd + v.expWe > 0)
            checkOutput({tag, "_mem_addr"}, {26'd0, lastStrobeAddr}, {26'd0, v.addr[7:2]});
    endtask

    task automatic holdPattern(input logic sel, input logic [1:0] trans, input int cycles);
        hsel   = sel;
        htrans = trans;
        hwrite = 1'b0;
        haddr  = 32'h10;
        hsize  = 2'd2;
        for (int c = 0; c < cycles; c++) begin
            @(negedge hclk);
            checkOutput("quiet_hready", {31'd0, hready_out}, 32'd1);
            checkOutput("quiet_hresp", {30'd0, hresp}, 32'd0);
            checkOutput("quiet_strobes", {30'd0, mem_rd, mem_we}, 32'd0);
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int rd0, we0, start;
        vec_t v;

        hrst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
        hsize = 2'd0; hwdata = '0; hburst = 3'd0; hprot = 4'd0;
        tieReady = 1'b1; forceReady = 1'b1;

        vecs[0]  = mkVec(1, 32'h10,  2'd2, 32'hDEADBEEF, 2'b00, 32'h0,        0, 0, 1);
        vecs[1]  = mkVec(0, 32'h10,  2'd2, 32'h0,        2'b00, 32'hDEADBEEF, 1, 1, 0);
        vecs[2]  = mkVec(1, 32'h12,  2'd0, 32'h00AA0000, 2'b00, 32'h0,        1, 1, 1);
        vecs[3]  = mkVec(0, 32'h10,  2'd2, 32'h0,        2'b00, 32'hDEAABEEF, 1, 1, 0);
        vecs[4]  = mkVec(1, 32'h10,  2'd1, 32'h00001234, 2'b00, 32'h0,        1, 1, 1);
        vecs[5]  = mkVec(0, 32'h10,  2'd2, 32'h0,        2'b00, 32'hDEAA1234, 1, 1, 0);
        vecs[6]  = mkVec(0, 32'h100, 2'd2, 32'h0,        2'b01, 32'h0,        1, 0, 0);
        vecs[7]  = mkVec(1, 32'h03,  2'd1, 32'h0000FFFF, 2'b01, 32'h0,        1, 0, 0);
        vecs[8]  = mkVec(0, 32'h10,  2'd3, 32'h0,        2'b01, 32'h0,        1, 0, 0);
        vecs[9]  = mkVec(0, 32'h10,  2'd2, 32'h0,        2'b00, 32'hDEAA1234, 1, 1, 0);
        vecs[10] = mkVec(1, 32'h12,  2'd1, 32'h55660000, 2'b00, 32'h0,        1, 1, 1);
        vecs[11] = mkVec(0, 32'h13,  2'd0, 32'h0,        2'b00, 32'h55661234, 1, 1, 0);

        // Reset values, while held and just after release.
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checkOutput("rst_hready", {31'd0, hready_out}, 32'd1);
        checkOutput("rst_hresp", {30'd0, hresp}, 32'd0);
        checkOutput("rst_hrdata", hrdata, 32'd0);
        checkOutput("rst_strobes", {30'd0, mem_rd, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge hclk);
        #1;
        hrst_n = 1'b1;
        @(negedge hclk);
        checkOutput("post_rst_hready", {31'd0, hready_out}, 32'd1);
        checkOutput("post_rst_hrdata", hrdata, 32'd0);
        @(posedge hclk);
        #1;

        // Isolated transfers from the vector table.
        for (int i = 0; i < 12; i++) begin
            runRow(vecs[i], $sformatf("row%0d", i));
        end

        // Back-to-back NONSEQ: write 0x00, read 0x00, write 0x04 with no idle between.
        start = cycleCnt;
        applyStimulus(mkVec(1, 32'h00, 2'd2, 32'h11223344, 2'b00, 32'h0,        0, 0, 1));
        applyStimulus(mkVec(0, 32'h00, 2'd2, 32'h0,        2'b00, 32'h11223344, 1, 1, 0));
        applyStimulus(mkVec(1, 32'h04, 2'd2, 32'hCAFEF00D, 2'b00, 32'h0,        0, 0, 1));
        waitReady();
        checkOutput("b2b_cycles", cycleCnt - start, 32'd5);
        runRow(mkVec(0, 32'h04, 2'd2, 32'h0, 2'b00, 32'hCAFEF00D, 1, 1, 0), "b2b_readback");

        // Reset asserted while a byte write sits in its read half: no write may reach the SRAM.
        applyStimulus(mkVec(1, 32'h11, 2'd0, 32'h0000FF00, 2'b00, 32'h0, 1, 1, 1));
        we0 = weCnt;
        hrst_n = 1'b0;
        @(negedge hclk);
        checkOutput("rmw_rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rmw_rst_hready", {31'd0, hready_out}, 32'd1);
        @(posedge hclk);
        #1;
        hrst_n = 1'b1;
        sbQ.delete();
        @(posedge hclk);
        #1;
        checkOutput("rmw_rst_no_write", weCnt - we0, 32'd0);
        runRow(mkVec(0, 32'h10, 2'd2, 32'h0, 2'b00, 32'h55661234, 1, 1, 0), "rmw_rst_readback");

        // IDLE/BUSY, deselected NONSEQ and NONSEQ with hready_in low cause no access.
        rd0 = rdCnt;
        we0 = weCnt;
        holdPattern(1'b1, 2'b00, 2);
        holdPattern(1'b1, 2'b01, 2);
        holdPattern(1'b0, 2'b10, 2);
        tieReady = 1'b0;
        forceReady = 1'b0;
        holdPattern(1'b1, 2'b10, 2);
        holdPattern(1'b0, 2'b00, 1);
        tieReady = 1'b1;
        holdPattern(1'b0, 2'b00, 2);
        checkOutput("quiet_rd_count", rdCnt - rd0, 32'd0);
        checkOutput("quiet_we_count", weCnt - we0, 32'd0);

        checkOutput("sb_drained", sbQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
AHB-lite slave that turns bus transfers from the TB_EVA master into single-port SRAM accesses on an EVA_MEM_WRAP-style memory (rd/we/addr/wdata/rdata, no byte enables). Sits on the hclk domain between the AHB bus and the RAM instance. Sub-word writes are done as internal read-modify-write. Out-of-range, misaligned and illegal-size transfers get a two-cycle ERROR response.

Parameters:
DW, 32, data width of AHB and SRAM (fixed 32; byte-lane logic assumes 4 lanes)
AW, 6, SRAM word-address width (64 words)

Ports:
hclk  in  1  clock
hrst_n  in  1  asynchronous active-low reset
hsel  in  1  slave select
htrans  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hwrite  in  1  1 = write
haddr  in  32  byte address
hwdata  in  DW  write data (data phase)
hsize  in  2  0 byte, 1 halfword, 2 word, 3 illegal
hburst  in  3  ignored
hprot  in  4  ignored
hready_in  in  1  bus ready (previous data phase complete)
hready_out  out  1  slave ready
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DW  read data
mem_rd  out  1  SRAM read strobe
mem_we  out  1  SRAM write strobe
mem_addr  out  AW  SRAM word address
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data, valid the cycle after mem_rd

Behaviour:
- Reset (async, hrst_n=0): state IDLE; hready_out=1, hresp=00, hrdata=0, mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0. An access in flight is dropped with no SRAM write.
- Accept: an address phase is accepted when hsel & htrans[1] & hready_in. The block captures hwrite, haddr, and hsize into registers. IDLE and BUSY transfers get OKAY and cause no access. An address phase is only accepted in states where hready_out=1.
- Error check at accept: any of these selects the ERR path:
  - haddr[31:AW+2] != 0
  - hsize=3
  - hsize=1 with haddr[0]=1
  - hsize=2 with haddr[1:0]!=0
- States (outputs decoded from state and captured registers):
  - IDLE: hready_out=1, hresp=00, no memory strobes. Accept → RD (read), WR (word write), RMW_RD (byte or half write), or ERR1.
  - RD: mem_rd=1, mem_addr=captured haddr[AW+1:2], hready_out=0 → RD_OUT.
  - RD_OUT: hrdata=mem_rdata, hready_out=1, hresp=00. The full word is returned for sub-word reads. Accepts the next transfer (same targets as IDLE), else → IDLE.
  - WR: mem_we=1, mem_wdata=hwdata, hready_out=1. Zero wait states. Accepts the next transfer.
  - RMW_RD: mem_rd=1, hwdata captured into a register, hready_out=0 → RMW_WR.
  - RMW_WR: mem_we=1, mem_wdata=merge(mem_rdata, captured hwdata), hready_out=1. Accepts the next transfer.
  - ERR1: hready_out=0, hresp=01 → ERR2.
  - ERR2: hready_out=1, hresp=01. Accepts the next transfer.
- Byte lanes (little-endian):
  - hsize=0: lane haddr[1:0].
  - hsize=1: lanes {2*haddr[1], 2*haddr[1]+1}.
  - Merge takes the written lanes from hwdata and the other lanes from mem_rdata.
- Latency, per transfer, address phase to completing data phase:
  - read: 1 wait state
  - word write: 0 wait states
  - sub-word write: 1 wait state
  - error: 1 wait state
- Pipelining: back-to-back transfers are accepted in every completing state. No SRAM port conflict can occur:
  - a write strobe happens only in the completing cycle;
  - the following read's strobe happens one cycle later.
- hrdata is 0 outside RD_OUT. mem_addr and mem_wdata hold their last values when no strobe is active.
- Read-after-write to the same address returns the new data, since the write completes before the read strobe.
- hready_in=0 with no pending data phase: no acceptance, state unchanged.

Test Plan:
1. Reset held, then released → hready_out=1, hresp=00, hrdata=0, mem_rd=mem_we=0. Assert hrst_n=0 during RMW_RD → mem_we never pulses and state returns to IDLE.
2. Word write 0x0000_0010 ← 0xDEADBEEF, then word read 0x10:
   - write: mem_we in the data-phase cycle, mem_addr=4.
   - read: 1 wait state, hrdata=0xDEADBEEF, hresp=00.
3. Word at 0x10 = 0xDEADBEEF. Byte write haddr=0x12, hwdata=0x00AA0000, then halfword write haddr=0x10, hwdata=0x00001234:
   - after the byte write, memory holds 0xDEAABEEF;
   - after the halfword write, read returns 0xDEAA1234;
   - each write shows 1 wait state.
4. Back-to-back NONSEQ transfers (word write 0x00, word read 0x00, word write 0x04) with hready_in tied to hready_out:
   - no bubbles beyond the specified wait states;
   - read returns the value just written.
5. Error cases → each gets ERR1 (hready_out=0, hresp=01) then ERR2 (hready_out=1, hresp=01), with no mem_rd or mem_we:
   - word read haddr=0x0000_0100 (out of range, AW=6);
   - halfword write haddr=0x0000_0003 (misaligned);
   - hsize=3.
   - A following valid read of 0x10 completes OKAY.
6. htrans=IDLE and BUSY with hsel=1, and NONSEQ with hsel=0 → no strobes, hready_out stays 1, hresp=00.
